// File: rtl/serial_clock_gen_pkg.sv
// Shared encodings for the framed serial clock generator.
package serial_clock_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_TRAIL = 3'd4
  } state_e;

  // Below two ticks per period there is no room for both levels.
  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/serial_clock_gen_clock_period_counter.sv
// Free-running period counter: cnt 0..div-1 while enabled, with edge/period pulses.
// Held at 0 while disabled so every enabled burst begins on a leading edge.
module clock_period_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_lead_edge,
  output logic             o_trail_edge,
  output logic             o_period_end
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_last;

  assign w_half = i_div >> 1;
  assign w_last = i_div - 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) r_cnt <= '0;
    else if (o_period_end) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt        = r_cnt;
  assign o_lead_edge  = i_en && (r_cnt == '0);
  assign o_trail_edge = i_en && (r_cnt == w_half);
  assign o_period_end = i_en && (r_cnt == w_last);

endmodule

// File: rtl/serial_clock_gen.sv
// Framed serial clock generator: lead / N symbols of B periods with gaps / trail,
// all CPOL/CPHA modes, with shift/sample strobes for the data shift engines.
module serial_clock_gen #(
  parameter int CNT_W  = 16,
  parameter int BITS_W = 6,
  parameter int SYMS_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CNT_W-1:0]  i_divisor,
  input  logic              i_clk_polarity,
  input  logic              i_clk_phase,
  input  logic [BITS_W-1:0] i_bits_per_sym,
  input  logic [SYMS_W-1:0] i_num_syms,
  input  logic [CNT_W-1:0]  i_lead_ticks,
  input  logic [CNT_W-1:0]  i_sym_delay_ticks,
  input  logic [CNT_W-1:0]  i_trail_ticks,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_clock_out,
  output logic              o_shift_strobe,
  output logic              o_sample_strobe,
  output logic              o_busy,
  output logic              o_done
);
  import serial_clock_gen_pkg::*;

  state_e             r_state, w_nstate;
  logic [CNT_W-1:0]   r_div, r_gap, r_trail, r_dly, w_dly_nxt;
  logic [BITS_W-1:0]  r_bits, r_bit, w_bit_nxt;
  logic [SYMS_W-1:0]  r_syms, r_sym, w_sym_nxt;
  logic               r_cpol, r_cpha;
  logic               r_abort_pend, w_abort_nxt;
  logic               r_done, w_done_nxt;

  logic [CNT_W-1:0]   w_div_clamp, w_cnt, w_trail_load, w_gap_load;
  logic               w_run, w_start_ok, w_degen;
  logic               w_lead_edge, w_trail_edge, w_period_end;
  logic               w_last_bit, w_last_sym, w_abort_any;

  assign w_div_clamp = (i_divisor < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : i_divisor;
  assign w_start_ok  = (r_state == ST_IDLE) && i_start;
  assign w_degen     = (i_bits_per_sym == '0) || (i_num_syms == '0);
  assign w_run       = (r_state == ST_RUN);

  clock_period_counter #(.CNT_W(CNT_W)) u_period (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (w_run),
    .i_div        (r_div),
    .o_cnt        (w_cnt),
    .o_lead_edge  (w_lead_edge),
    .o_trail_edge (w_trail_edge),
    .o_period_end (w_period_end)
  );

  // Config is sampled once per transfer so the register block may reprogram freely.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div   <= '0;
      r_gap   <= '0;
      r_trail <= '0;
      r_bits  <= '0;
      r_syms  <= '0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
    end else if (w_start_ok) begin
      r_div   <= w_div_clamp;
      r_gap   <= i_sym_delay_ticks;
      r_trail <= i_trail_ticks;
      r_bits  <= i_bits_per_sym;
      r_syms  <= i_num_syms;
      r_cpol  <= i_clk_polarity;
      r_cpha  <= i_clk_phase;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_dly        <= '0;
      r_bit        <= '0;
      r_sym        <= '0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_dly        <= w_dly_nxt;
      r_bit        <= w_bit_nxt;
      r_sym        <= w_sym_nxt;
      r_abort_pend <= w_abort_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign w_trail_load = (r_trail == '0) ? '0 : r_trail - 1'b1;
  assign w_gap_load   = (r_gap == '0) ? '0 : r_gap - 1'b1;
  assign w_last_bit   = (BITS_W'(r_bit + 1'b1) == r_bits);
  assign w_last_sym   = (SYMS_W'(r_sym + 1'b1) == r_syms);
  assign w_abort_any  = i_abort || r_abort_pend;

  // Zero-length delay states are skipped by jumping straight past them.
  always_comb begin
    w_nstate    = r_state;
    w_dly_nxt   = (r_dly == '0) ? '0 : r_dly - 1'b1;
    w_bit_nxt   = r_bit;
    w_sym_nxt   = r_sym;
    w_abort_nxt = r_abort_pend;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dly_nxt   = '0;
        w_bit_nxt   = '0;
        w_sym_nxt   = '0;
        w_abort_nxt = 1'b0;
        if (i_start) begin
          if (w_degen) begin
            w_done_nxt = 1'b1;
          end else if (i_lead_ticks == '0) begin
            w_nstate = ST_RUN;
          end else begin
            w_nstate  = ST_LEAD;
            w_dly_nxt = i_lead_ticks - 1'b1;
          end
        end
      end
      ST_LEAD, ST_GAP: begin
        if (i_abort) begin
          w_nstate   = (r_trail == '0) ? ST_IDLE : ST_TRAIL;
          w_dly_nxt  = w_trail_load;
          w_done_nxt = (r_trail == '0);
        end else if (r_dly == '0) begin
          w_nstate = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_abort) w_abort_nxt = 1'b1;
        if (w_period_end) begin
          if (w_last_bit) begin
            w_bit_nxt = '0;
            w_sym_nxt = r_sym + 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
          if (w_abort_any || (w_last_bit && w_last_sym)) begin
            w_nstate   = (r_trail == '0) ? ST_IDLE : ST_TRAIL;
            w_dly_nxt  = w_trail_load;
            w_done_nxt = (r_trail == '0);
          end else if (w_last_bit && (r_gap != '0)) begin
            w_nstate  = ST_GAP;
            w_dly_nxt = w_gap_load;
          end
        end
      end
      ST_TRAIL: begin
        if (r_dly == '0) begin
          w_nstate   = ST_IDLE;
          w_done_nxt = 1'b1;
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  // Active level occupies cnt < div/2, so an odd divisor gets the shorter active half.
  assign o_clock_out     = (r_state == ST_IDLE) ? i_clk_polarity :
                           (w_run && (w_cnt < (r_div >> 1))) ? ~r_cpol : r_cpol;
  assign o_sample_strobe = r_cpha ? w_trail_edge : w_lead_edge;
  assign o_shift_strobe  = r_cpha ? w_lead_edge : w_trail_edge;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;

endmodule

// File: tb/tb_serial_clock_gen.sv
// Directed bench for serial_clock_gen: timing, edge counts and strobe alignment per mode.
module tb_serial_clock_gen;
  localparam int CNT_W  = 16;
  localparam int BITS_W = 6;
  localparam int SYMS_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CNT_W-1:0]  divisor = 16'd4;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [BITS_W-1:0] bits = 6'd1;
  logic [SYMS_W-1:0] syms = 8'd1;
  logic [CNT_W-1:0]  lead = '0;
  logic [CNT_W-1:0]  gap = '0;
  logic [CNT_W-1:0]  trail = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              clock_out, shift_s, sample_s, busy, done;

  serial_clock_gen #(.CNT_W(CNT_W), .BITS_W(BITS_W), .SYMS_W(SYMS_W)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_divisor         (divisor),
    .i_clk_polarity    (cpol),
    .i_clk_phase       (cpha),
    .i_bits_per_sym    (bits),
    .i_num_syms        (syms),
    .i_lead_ticks      (lead),
    .i_sym_delay_ticks (gap),
    .i_trail_ticks     (trail),
    .i_start           (start),
    .i_abort           (abort),
    .o_clock_out       (clock_out),
    .o_shift_strobe    (shift_s),
    .o_sample_strobe   (sample_s),
    .o_busy            (busy),
    .o_done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: running totals and absolute edge times, sampled mid-cycle.
  logic prev_clk = 1'b0;
  int   edge_t [0:255];
  int   n_edges = 0, n_samp = 0, n_shift = 0, n_srise = 0, n_sfall = 0, n_done = 0, n_busy = 0;
  always @(negedge clk) begin
    prev_clk <= clock_out;
    if (clock_out !== prev_clk) begin
      edge_t[n_edges[7:0]] <= cyc;
      n_edges <= n_edges + 1;
    end
    if (sample_s === 1'b1) begin
      n_samp <= n_samp + 1;
      if (clock_out === 1'b1 && prev_clk === 1'b0) n_srise <= n_srise + 1;
    end
    if (shift_s === 1'b1) begin
      n_shift <= n_shift + 1;
      if (clock_out === 1'b0 && prev_clk === 1'b1) n_sfall <= n_sfall + 1;
    end
    if (done === 1'b1) n_done <= n_done + 1;
    if (busy === 1'b1) n_busy <= n_busy + 1;
  end

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int t0, b_edges, b_samp, b_shift, b_srise, b_sfall, b_done, b_busy;

  task automatic setup(input int d, input logic p, input logic h, input int b, input int n,
                       input int ld, input int gp, input int tr);
    divisor = CNT_W'(d);
    cpol    = p;
    cpha    = h;
    bits    = BITS_W'(b);
    syms    = SYMS_W'(n);
    lead    = CNT_W'(ld);
    gap     = CNT_W'(gp);
    trail   = CNT_W'(tr);
  endtask

  // Leaves the caller at the negedge of cycle t+1 (start was high in cycle t).
  task automatic pulse_start;
    repeat (2) @(negedge clk);
    start   = 1'b1;
    t0      = cyc;
    b_edges = n_edges;
    b_samp  = n_samp;
    b_shift = n_shift;
    b_srise = n_srise;
    b_sfall = n_sfall;
    b_done  = n_done;
    b_busy  = n_busy;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int dt);
    dt = -1;
    if (done === 1'b1) dt = cyc - t0;
    else begin
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          dt = cyc - t0;
          break;
        end
      end
    end
  endtask

  function automatic int edge_at(input int i);
    return edge_t[(b_edges + i) % 256] - t0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dt;
    int dvals [3];
    dvals = '{0, 1, 2};

    // Reset state; polarity is live while idle
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clock_cpol1", int'(clock_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sample", int'(sample_s), 0);
    chk("rst_shift", int'(shift_s), 0);
    cpol = 1'b0;
    @(negedge clk);
    chk("rst_clock_cpol0", int'(clock_out), 0);
    rst = 1'b0;

    // Mode 0, div 4, B8 N1, lead 2, trail 2; config changed mid-transfer must not matter
    setup(4, 1'b0, 1'b0, 8, 1, 2, 0, 2);
    pulse_start();
    divisor = 16'd9;
    bits    = 6'd3;
    wait_done(dt);
    chk("m0_done_time", dt, 37);
    repeat (3) @(negedge clk);
    chk("m0_edges", n_edges - b_edges, 16);
    chk("m0_first_edge", edge_at(0), 3);
    chk("m0_high_len", edge_at(1) - edge_at(0), 2);
    chk("m0_samples", n_samp - b_samp, 8);
    chk("m0_samp_rise", n_srise - b_srise, 8);
    chk("m0_shifts", n_shift - b_shift, 8);
    chk("m0_shift_fall", n_sfall - b_sfall, 8);
    chk("m0_busy_cycles", n_busy - b_busy, 36);

    // Mode 3, div 5, B4 N3, lead 1, gap 10, trail 1
    setup(5, 1'b1, 1'b1, 4, 3, 1, 10, 1);
    repeat (2) @(negedge clk);
    chk("m3_idle_high", int'(clock_out), 1);
    pulse_start();
    wait_done(dt);
    chk("m3_done_time", dt, 83);
    repeat (3) @(negedge clk);
    chk("m3_edges", n_edges - b_edges, 24);
    chk("m3_first_edge", edge_at(0), 2);
    chk("m3_low_len", edge_at(1) - edge_at(0), 2);
    chk("m3_period", edge_at(2) - edge_at(0), 5);
    chk("m3_gap1", edge_at(8) - edge_at(6), 15);
    chk("m3_gap2", edge_at(16) - edge_at(14), 15);
    chk("m3_samples", n_samp - b_samp, 12);
    chk("m3_samp_rise", n_srise - b_srise, 12);
    chk("m3_shift_fall", n_sfall - b_sfall, 12);

    // Divisor clamp: 0, 1 and 2 all give one tick per level
    foreach (dvals[i]) begin
      setup(dvals[i], 1'b0, 1'b0, 2, 1, 0, 0, 0);
      pulse_start();
      wait_done(dt);
      chk($sformatf("clamp_done_d%0d", dvals[i]), dt, 5);
      repeat (3) @(negedge clk);
      chk($sformatf("clamp_edges_d%0d", dvals[i]), n_edges - b_edges, 4);
      chk($sformatf("clamp_level_d%0d", dvals[i]), edge_at(1) - edge_at(0), 1);
    end

    // Abort inside period index 2, plus a start while busy
    setup(4, 1'b0, 1'b0, 8, 1, 0, 0, 2);
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(dt);
    chk("abort_done_time", dt, 15);
    repeat (6) @(negedge clk);
    chk("abort_edges", n_edges - b_edges, 6);
    chk("abort_samples", n_samp - b_samp, 3);
    chk("abort_done_cnt", n_done - b_done, 1);
    chk("abort_busy_cycles", n_busy - b_busy, 14);

    // Reset in RUN, then a fresh transfer
    setup(4, 1'b1, 1'b0, 8, 1, 0, 0, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_clock", int'(clock_out), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", n_done - b_done, 0);
    setup(2, 1'b0, 1'b0, 2, 1, 0, 0, 0);
    pulse_start();
    wait_done(dt);
    chk("postrst_done_time", dt, 5);
    repeat (3) @(negedge clk);
    chk("postrst_edges", n_edges - b_edges, 4);

    // Degenerate transfers: B=0, then N=0
    for (int v = 0; v < 2; v++) begin
      setup(4, 1'b0, 1'b0, (v == 0) ? 0 : 4, (v == 0) ? 5 : 0, 2, 0, 2);
      pulse_start();
      wait_done(dt);
      chk($sformatf("degen%0d_done_time", v), dt, 1);
      repeat (5) @(negedge clk);
      chk($sformatf("degen%0d_busy", v), n_busy - b_busy, 0);
      chk($sformatf("degen%0d_edges", v), n_edges - b_edges, 0);
      chk($sformatf("degen%0d_done_cnt", v), n_done - b_done, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
